// File: rtl/button_conditioner_if.sv
// Button front-end bus: raw inputs and timebase in, conditioned levels/pulses out.
interface button_conditioner_if #(
    parameter int NUM_BTN = 4
);
    logic [15:0]        ticks_per_milli;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_clean;
    logic               chord;

    modport master (
        output ticks_per_milli,
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_clean,
        input  chord
    );

    modport slave (
        input  ticks_per_milli,
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_clean,
        output chord
    );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes and debounces push buttons against a ms timebase,
// emitting levels, edge pulses and a chord-suppressed one-hot bus.
module button_conditioner #(
    parameter int NUM_BTN     = 4,
    parameter int DEBOUNCE_MS = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    button_conditioner_if.slave bus
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        REL_PEND
    } state_e;

    localparam logic [7:0] DB = 8'(DEBOUNCE_MS);

    logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];
    logic [NUM_BTN-1:0] sync_d [SYNC_STAGES];
    logic [NUM_BTN-1:0] s;

    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [15:0] tick_max;
    logic        ms_tick;

    state_e      state_q [NUM_BTN];
    state_e      state_d [NUM_BTN];
    logic [7:0]  cnt_q   [NUM_BTN];
    logic [7:0]  cnt_d   [NUM_BTN];
    logic [7:0]  cnt_inc;

    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic               chord_q, chord_d;

    int   pop;
    logic multi;

    always_comb begin
        sync_d[0] = bus.btn_raw;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Zero period is treated as one cycle per ms
    always_comb begin
        tick_max   = (bus.ticks_per_milli == 16'd0) ? 16'd1
                                                    : bus.ticks_per_milli;
        ms_tick    = (tick_cnt_q == tick_max - 16'd1);
        tick_cnt_d = ms_tick ? 16'd0 : tick_cnt_q + 16'd1;
    end

    always_comb begin
        cnt_inc   = '0;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            cnt_inc    = cnt_q[i] + 8'd1;
            unique case (state_q[i])
                RELEASED: begin
                    if (s[i]) begin
                        state_d[i] = PRESS_PEND;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_PEND: begin
                    if (!s[i]) begin
                        state_d[i] = RELEASED;
                    end else if (ms_tick) begin
                        cnt_d[i] = cnt_inc;
                        if (cnt_inc == DB) begin
                            state_d[i] = PRESSED;
                            level_d[i] = 1'b1;
                            press_d[i] = 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (!s[i]) begin
                        state_d[i] = REL_PEND;
                        cnt_d[i]   = '0;
                    end
                end
                REL_PEND: begin
                    if (s[i]) begin
                        state_d[i] = PRESSED;
                    end else if (ms_tick) begin
                        cnt_d[i] = cnt_inc;
                        if (cnt_inc == DB) begin
                            state_d[i]   = RELEASED;
                            level_d[i]   = 1'b0;
                            release_d[i] = 1'b1;
                        end
                    end
                end
                default: state_d[i] = RELEASED;
            endcase
        end
    end

    always_comb begin
        pop = 0;
        for (int i = 0; i < NUM_BTN; i++) begin
            pop = pop + 32'(level_q[i]);
        end
        multi = (pop >= 2);
    end

    // Chord stays latched until every button is released
    always_comb begin
        chord_d = chord_q;
        if (multi) begin
            chord_d = 1'b1;
        end else if (level_q == '0) begin
            chord_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            tick_cnt_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            chord_q   <= 1'b0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            tick_cnt_q <= tick_cnt_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            chord_q   <= chord_d;
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.chord       = chord_q;
    assign bus.btn_clean   = (chord_q || multi) ? '0 : level_q;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage that feeds the game controller's button input.
- Synchronizes the four raw, asynchronous push-button lines and debounces each one against a millisecond timebase.
- Produces clean levels, single-cycle press/release pulses, and a chord-suppressed one-hot bus.
- The controller decodes that one-hot bus directly, so multi-button chords never reach it.

Parameters:
- NUM_BTN, 4, number of button channels.
- DEBOUNCE_MS, 10, stable time in ms required to accept a level change; legal range 1..255.
- SYNC_STAGES, 2, synchronizer flop depth; legal range ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ticks_per_milli  in  16  clk cycles per millisecond; value 0 is treated as 1.
- btn_raw  in  NUM_BTN  asynchronous button inputs, active-high.
- btn_level  out  NUM_BTN  registered debounced level per button.
- btn_press  out  NUM_BTN  1-cycle pulse when a debounced level rises.
- btn_release  out  NUM_BTN  1-cycle pulse when a debounced level falls.
- btn_clean  out  NUM_BTN  btn_level, forced to 0 while chord lockout is active.
- chord  out  1  chord lockout flag.

Behaviour:
- Reset (synchronous):
  - Synchronizer flops, tick counter, all per-channel counters and chord are cleared to 0.
  - Every FSM goes to RELEASED.
  - All outputs are 0.
  - Reset mid-press: the channel restarts from RELEASED; a still-held button is re-debounced and produces a fresh btn_press.
- Synchronizer: each bit passes through SYNC_STAGES flops. The synced value s[i] lags btn_raw by SYNC_STAGES cycles.
- Timebase:
  - A 16-bit tick_cnt increments every cycle.
  - When tick_cnt == max(ticks_per_milli,1)-1, tick_cnt returns to 0 and ms_tick is high for that one cycle.
  - A change of ticks_per_milli takes effect on the next compare. If tick_cnt already exceeds the new value, it wraps through 16 bits. This is tolerated and is not a reset condition.
- Per-channel FSM with an 8-bit counter cnt. States RELEASED, PRESS_PEND, PRESSED, REL_PEND:
  - RELEASED: if s=1 → PRESS_PEND, cnt←0.
  - PRESS_PEND: if s=0 → RELEASED, no pulse (glitch rejected). Otherwise, on ms_tick, cnt←cnt+1. On the ms_tick where cnt+1 == DEBOUNCE_MS → PRESSED, btn_level←1, btn_press pulse.
  - PRESSED: if s=0 → REL_PEND, cnt←0.
  - REL_PEND: if s=1 → PRESSED, no pulse. Otherwise count as in PRESS_PEND. On reaching DEBOUNCE_MS → RELEASED, btn_level←0, btn_release pulse.
  - Effective debounce window: (DEBOUNCE_MS-1)·T to DEBOUNCE_MS·T after entering a pending state, where T = ticks_per_milli cycles.
  - A glitch check on s takes priority over a coincident ms_tick.
- Pulses: btn_press and btn_release are registered, high for exactly one cycle, and aligned with the btn_level edge.
- Chord lockout:
  - chord register is set on the cycle after popcount(btn_level) ≥ 2.
  - chord is cleared on the cycle after btn_level == 0.
  - Set has priority only when both conditions could apply; they cannot coincide.
  - btn_clean = (chord or popcount(btn_level) ≥ 2) ? 0 : btn_level. This is combinational from flops only, so at most one bit of btn_clean is ever high.
  - btn_press is not masked by chord. btn_clean stays 0 after a chord until every button is released, including the remaining single button.
- Simultaneous events:
  - Channels are fully independent; several channels may pulse in the same cycle.
  - Press and release of the same channel can never pulse in the same cycle.
- Latency: a clean raw edge produces a level change 1 + SYNC_STAGES + (DEBOUNCE_MS-1)·T … DEBOUNCE_MS·T cycles later.

Test Plan:
- Config for all scenarios: ticks_per_milli=4, DEBOUNCE_MS=3, SYNC_STAGES=2.
- Reset values: assert rst 5 cycles with btn_raw=4'b1111 → all outputs 0 throughout. After release, btn_level=1111 within 15 cycles and chord=1 one cycle later.
- Clean press: raw BTN1 held high from cycle 0 → btn_level[1] rises between cycle 11 and 15, exactly one btn_press[1] pulse, btn_clean=0010. Release raw → btn_level[1] falls 11–15 cycles later with one btn_release[1] pulse.
- Bounce rejection: BTN2 toggles every 3 cycles for 40 cycles, then held high → no pulse during toggling, single press pulse 11–15 cycles after the final stable edge.
- Chord: BTN0 debounced, then BTN3 debounced → btn_clean goes 0001 → 0000 in the cycle btn_level becomes 1001. Release BTN3 only → btn_clean stays 0000. Release BTN0 → chord clears one cycle after btn_level=0000.
- ticks_per_milli=0: BTN0 press → level rises between 5 and 6 cycles after the raw edge (T=1).
- Reset mid-press: BTN1 in PRESSED, pulse rst for 1 cycle with BTN1 still held → level 0, then a new btn_press[1] within 15 cycles.
